icache_ctrl_cwf: RTL

//  Parametrised L1 I-cache controller: tag lookup, hit read, burst line refill from IM.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_ctrl_cwf_if.sv | 38 +++
 rtl/icache_refill_seq.sv | 49 ++++
 rtl/icache_ctrl_cwf.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and helpers for the L1 I-cache controller.
// Holds the FSM state encoding and the data-bank one-hot decoder.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CMP,
    REFILL,
    RESP
  } icache_state_e;

  localparam int WORD_BYTES = 4;
  localparam int MAX_WORDS  = 16;

  function automatic logic [MAX_WORDS-1:0] onehot(
    input logic [3:0] idx
  );
    return MAX_WORDS'(1) << idx;
  endfunction

endpackage

// File: rtl/icache_ctrl_cwf_if.sv
// icache_ctrl_cwf_if: IF-stage, tag/data SRAM and IM port bundle.
// master = cache controller, slave = the surrounding pipeline/memories.
interface icache_ctrl_cwf_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
);

  logic [ADDR_W-1:0]     addr;
  logic                  req;
  logic                  hit;
  logic                  mem_ready;
  logic                  stall_ext;
  logic                  tag_cs;
  logic                  tag_oe;
  logic                  tag_web;
  logic [LINE_WORDS-1:0] data_cs;
  logic                  data_oe;
  logic [3:0]            data_web;
  logic                  stall;
  logic                  rsp_valid;
  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;

  modport master (
    input  addr, req, hit, mem_ready, stall_ext,
    output tag_cs, tag_oe, tag_web,
    output data_cs, data_oe, data_web,
    output stall, rsp_valid, mem_req, mem_addr
  );

  modport slave (
    output addr, req, hit, mem_ready, stall_ext,
    input  tag_cs, tag_oe, tag_web,
    input  data_cs, data_oe, data_web,
    input  stall, rsp_valid, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_refill_seq.sv
// icache_refill_seq: refill beat counter and critical-word-first
// word/address generator; beat moves only on accepted, unstalled beats.
module icache_refill_seq
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int CWF        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_adv,
  input  logic [ADDR_W-3:0]             i_line,
  output logic [$clog2(LINE_WORDS)-1:0] o_word,
  output logic                          o_last_pos,
  output logic                          o_last,
  output logic [ADDR_W-1:0]             o_mem_addr
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int B_W   = $clog2(WORD_BYTES);

  logic [OFF_W-1:0] r_beat;
  logic [OFF_W-1:0] w_crit;

  assign w_crit = i_line[OFF_W-1:0];

  // modulo-LINE_WORDS wrap falls out of the OFF_W-bit add
  assign o_word = (CWF != 0) ? w_crit + r_beat
                             : r_beat;

  assign o_last_pos =
    (r_beat == OFF_W'(LINE_WORDS - 1));
  assign o_last = i_adv && o_last_pos;

  assign o_mem_addr = {
    i_line[ADDR_W-3:OFF_W], o_word, B_W'(0)
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat <= '0;
    end else if (i_adv) begin
      r_beat <= o_last ? '0
                       : r_beat + OFF_W'(1);
    end
  end

endmodule

// File: rtl/icache_ctrl_cwf.sv
// icache_ctrl_cwf: L1 I-cache controller, parametric line, CWF refill.
// Define ICACHE_PERF_CNT_EN to add saturating access/miss counters.
module icache_ctrl_cwf
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int CWF        = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  icache_ctrl_cwf_if.master bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  access_cnt,
  output logic [CNT_W-1:0]  miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);

  if (LINE_WORDS < 2 || LINE_WORDS > MAX_WORDS ||
      (LINE_WORDS & (LINE_WORDS - 1)) != 0 ||
      CNT_W < 1) begin : g_bad_cfg
    $error("icache_ctrl_cwf: bad parameters");
  end

  icache_state_e     r_state;
  icache_state_e     w_next;
  logic [ADDR_W-3:0] r_line;
  logic [OFF_W-1:0]  w_word;
  logic              w_adv;
  logic              w_last_pos;
  logic              w_last;
  logic [ADDR_W-1:0] w_mem_addr;

  assign w_adv = (r_state == REFILL) &&
                 bus.mem_ready && !bus.stall_ext;

  icache_refill_seq #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS),
    .CWF        (CWF)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .i_adv      (w_adv),
    .i_line     (r_line),
    .o_word     (w_word),
    .o_last_pos (w_last_pos),
    .o_last     (w_last),
    .o_mem_addr (w_mem_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // line address is latched once per request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line <= '0;
    end else if (r_state == IDLE && bus.req) begin
      r_line <= bus.addr[ADDR_W-1:2];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.req) w_next = LOOKUP;
      LOOKUP:  w_next = CMP;
      CMP:     w_next = bus.hit ? RESP : REFILL;
      REFILL:  if (w_last) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign bus.mem_addr = w_mem_addr;

  always_comb begin
    bus.tag_cs    = 1'b0;
    bus.tag_oe    = 1'b0;
    bus.tag_web   = 1'b1;
    bus.data_cs   = '0;
    bus.data_oe   = 1'b1;
    bus.data_web  = 4'hF;
    bus.stall     = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_req   = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.stall   = bus.req;
        bus.data_cs = LINE_WORDS'(onehot(
          4'(bus.addr[OFF_W+1:2])));
      end
      LOOKUP, CMP: begin
        bus.tag_cs = 1'b1;
        bus.tag_oe = 1'b1;
        bus.stall  = 1'b1;
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.stall    = 1'b1;
        bus.data_cs  = LINE_WORDS'(onehot(4'(w_word)));
        bus.data_oe  = 1'b0;
        bus.data_web = 4'h0;
        bus.tag_cs   = w_last_pos;
        bus.tag_web  = !w_last_pos;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.data_cs   = LINE_WORDS'(onehot(
          4'(r_line[OFF_W-1:0])));
      end
      default: ;
    endcase
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_miss;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_miss <= '0;
    end else begin
      if (r_state == IDLE && bus.req && r_acc != '1)
        r_acc <= r_acc + CNT_W'(1);
      if (r_state == CMP && !bus.hit && r_miss != '1)
        r_miss <= r_miss + CNT_W'(1);
    end
  end

  assign access_cnt = r_acc;
  assign miss_cnt   = r_miss;
`endif

endmodule
